// File: rtl/seg7_scan_drv_if.sv
// Load/staging bus and display pins of the seven-segment scan driver.
// The master side loads values; the slave side (the driver) scans the display.
interface seg7_scan_drv_if;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        pending;
  logic        frame_tick;

  modport master (
    output load, data_in, dp_in, blank_in,
    input  an, seg, dp, pending, frame_tick
  );

  modport slave (
    input  load, data_in, dp_in, blank_in,
    output an, seg, dp, pending, frame_tick
  );
endinterface

// File: rtl/seg7_scan_drv.sv
// Four-digit multiplexed common-anode seven-segment driver with per-slot dead time.
// Loads are staged and only copied to the display registers at a frame boundary.
module seg7_scan_drv #(
  parameter int SCAN_DIV = 100000,
  parameter int GUARD    = 1000
) (
  input logic           clk_100MHz,
  input logic           rst,
  seg7_scan_drv_if.slave bus
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          slot_end;
  logic          boundary;

  logic [15:0]   stage_data;
  logic [3:0]    stage_dp;
  logic [3:0]    stage_blank;
  logic          pending;

  logic [15:0]   disp_data;
  logic [3:0]    disp_dp;
  logic [3:0]    disp_blank;

  logic [3:0]    nib;
  logic [6:0]    dec;
  logic          digit_on;

  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic          dp_q;
  logic          tick_q;

  assign slot_end = (cnt == CNT_LAST);
  assign boundary = slot_end && (idx == 2'd3);

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A load in the boundary cycle still lets the old staging reach the display,
  // while the new value is staged and stays pending for the following frame.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      stage_data  <= '0;
      stage_dp    <= '0;
      stage_blank <= '0;
      pending     <= 1'b0;
      disp_data   <= '0;
      disp_dp     <= '0;
      disp_blank  <= 4'hF;
    end else begin
      if (boundary && pending) begin
        disp_data  <= stage_data;
        disp_dp    <= stage_dp;
        disp_blank <= stage_blank;
      end
      if (bus.load) begin
        stage_data  <= bus.data_in;
        stage_dp    <= bus.dp_in;
        stage_blank <= bus.blank_in;
        pending     <= 1'b1;
      end else if (boundary) begin
        pending <= 1'b0;
      end
    end
  end

  always_comb begin
    nib      = disp_data[{idx, 2'b00} +: 4];
    digit_on = ~disp_blank[idx];
    dec      = 7'h7F;
    case (nib)
      4'h0: dec = 7'h40;
      4'h1: dec = 7'h79;
      4'h2: dec = 7'h24;
      4'h3: dec = 7'h30;
      4'h4: dec = 7'h19;
      4'h5: dec = 7'h12;
      4'h6: dec = 7'h02;
      4'h7: dec = 7'h78;
      4'h8: dec = 7'h00;
      4'h9: dec = 7'h10;
      4'hA: dec = 7'h08;
      4'hB: dec = 7'h03;
      4'hC: dec = 7'h46;
      4'hD: dec = 7'h21;
      4'hE: dec = 7'h06;
      4'hF: dec = 7'h0E;
      default: dec = 7'h7F;
    endcase
  end

  // All anodes stay off for the first GUARD cycles of a slot to avoid ghosting.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      an_q   <= 4'hF;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      tick_q <= boundary && pending;
      if ((cnt < CNT_GUARD) || !digit_on) begin
        an_q  <= 4'hF;
        seg_q <= 7'h7F;
        dp_q  <= 1'b1;
      end else begin
        an_q  <= ~(4'b0001 << idx);
        seg_q <= dec;
        dp_q  <= ~disp_dp[idx];
      end
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.pending    = pending;
  assign bus.frame_tick = tick_q;

endmodule
